// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: sizes, complex word type, bit-reverse helper
// and the output streamer FSM encoding.
package fft_pkg;

    localparam int N_POINTS = 1024;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        cplx_t             data;
        logic [ADDR_W-1:0] tag;
    } fifo_ent_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } out_state_t;

    // Pure wire permutation: bit i of the result is bit ADDR_W-1-i of idx.
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] idx);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = idx[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry FIFO of complex words with a bin tag; the head entry is held
// stable in a register until it is popped.
module fft_skid_fifo
    import fft_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  fifo_ent_t in_ent,
    output fifo_ent_t head,
    output logic      head_vld,
    output logic [1:0] occ
);

    fifo_ent_t  head_r;
    fifo_ent_t  tail_r;
    logic [1:0] cnt_r;

    // Head/tail storage and occupancy; the tail only feeds the head on a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= '0;
            tail_r <= '0;
            cnt_r  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        head_r <= in_ent;
                        cnt_r  <= 2'd1;
                    end else if (cnt_r == 2'd1) begin
                        tail_r <= in_ent;
                        cnt_r  <= 2'd2;
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                2'b01: begin
                    if (cnt_r == 2'd2) begin
                        head_r <= tail_r;
                    end else begin
                        head_r <= head_r;
                    end
                    cnt_r <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= in_ent;
                    end else begin
                        head_r <= in_ent;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign head     = head_r;
    assign head_vld = (cnt_r != 2'd0);
    assign occ      = cnt_r;

endmodule

// File: rtl/fft_output_streamer.sv
// Drains the FFT RAM in bit-reversed order and streams bins in natural order.
// Optional FFT_OUT_NORM_EN applies the 1/N arithmetic shift at the FIFO write.
module fft_output_streamer #(
    parameter int N_POINTS = fft_pkg::N_POINTS,
    parameter int ADDR_W   = fft_pkg::ADDR_W,
    parameter int DATA_W   = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              scan,
    output logic [ADDR_W-1:0] ram_index,
    input  logic [DATA_W-1:0] ram_real_i,
    input  logic [DATA_W-1:0] ram_imag_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [ADDR_W-1:0] out_bin,
    output logic              out_last
);
    import fft_pkg::*;

    out_state_t        state_r;
    out_state_t        state_nxt_s;
    logic [ADDR_W-1:0] rd_cnt_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_tag_r;
    logic              busy_r;
    logic              scan_r;
    logic              done_r;
    logic              scan_nxt_s;
    logic              issue_s;
    logic              pop_s;
    logic              final_pop_s;
    logic [1:0]        occ_s;
    logic [1:0]        credit_s;
    logic              head_vld_s;
    fifo_ent_t         head_s;
    fifo_ent_t         push_ent_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: start only counts in IDLE, the last read ends STREAM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_STREAM;
                else       state_nxt_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (issue_s && (rd_cnt_r == ADDR_W'(N_POINTS-1))) state_nxt_s = ST_DRAIN;
                else                                             state_nxt_s = ST_STREAM;
            end
            ST_DRAIN: begin
                if (final_pop_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // A same-cycle pop frees a slot, so reads keep up at one per cycle
    // while FIFO plus in-flight never exceeds two entries.
    assign credit_s    = occ_s + {1'b0, inflight_r};
    assign pop_s       = head_vld_s && out_ready;
    assign final_pop_s = pop_s && (head_s.tag == ADDR_W'(N_POINTS-1));

    // FSM outputs: read issue and next RAM ownership
    always_comb begin
        issue_s    = 1'b0;
        scan_nxt_s = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_STREAM: issue_s = (credit_s < 2'd2) || pop_s;
            default:   issue_s = 1'b0;
        endcase
    end

    // Read counter, in-flight tag and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_r       <= '0;
            inflight_r     <= 1'b0;
            inflight_tag_r <= '0;
            busy_r         <= 1'b0;
            scan_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            busy_r     <= scan_nxt_s;
            scan_r     <= scan_nxt_s;
            done_r     <= (state_r == ST_DRAIN) && final_pop_s;
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_tag_r <= rd_cnt_r;
            end else begin
                inflight_tag_r <= inflight_tag_r;
            end
            if ((state_r == ST_IDLE) && start) begin
                rd_cnt_r <= '0;
            end else if (issue_s) begin
                rd_cnt_r <= rd_cnt_r + ADDR_W'(1);
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end
        end
    end

`ifdef FFT_OUT_NORM_EN
    assign push_ent_s.data.re = DATA_W'($signed(ram_real_i) >>> ADDR_W);
    assign push_ent_s.data.im = DATA_W'($signed(ram_imag_i) >>> ADDR_W);
`else
    assign push_ent_s.data.re = ram_real_i;
    assign push_ent_s.data.im = ram_imag_i;
`endif
    assign push_ent_s.tag = inflight_tag_r;

    fft_skid_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_r),
        .pop      (pop_s),
        .in_ent   (push_ent_s),
        .head     (head_s),
        .head_vld (head_vld_s),
        .occ      (occ_s)
    );

    assign ram_index = bitrev(rd_cnt_r);
    assign busy      = busy_r;
    assign scan      = scan_r;
    assign done      = done_r;
    assign out_valid = head_vld_s;
    assign out_real  = head_s.data.re;
    assign out_imag  = head_s.data.im;
    assign out_bin   = head_s.tag;
    assign out_last  = head_vld_s && (head_s.tag == ADDR_W'(N_POINTS-1));

endmodule
